// File: rtl/risc_mem_pkg.sv
// Shared constants, FSM state type and address range helper for the
// processor data-memory responder.
package risc_mem_pkg;

    localparam int DW     = 128;  // data word width
    localparam int DEPTH  = 256;  // number of storage words
    localparam int RD_LAT = 2;    // accept edge to rd_valid, in cycles
    localparam int ADDR_W = 16;   // processor word-address width

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Range check on the full processor address, so addresses at or above
    // depth never alias onto low words through truncation.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int                depth);
        return 32'(addr) < 32'(depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Storage array: one synchronous write port and one registered read port.
// A read and a write to the same word on one edge returns the new data.
module mem_array #(
    parameter int DW    = 128,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port plus write-first registered read port.
    // NOTE: the array and its read register carry no reset; the owner zeroes
    // the contents with an explicit sweep, which keeps this mappable to RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Processor data-memory responder: zero-fills storage after reset, then
// serves one write and one read per cycle with a fixed two-cycle read
// latency and out-of-range error reporting.
module data_mem_responder #(
    parameter int DW    = risc_mem_pkg::DW,
    parameter int DEPTH = risc_mem_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   address,
    input  logic [DW-1:0] w_data,
    input  logic          mw_en,
    input  logic          rd_en,
    output logic [DW-1:0] D_in,
    output logic          rd_valid,
    output logic          busy,
    output logic          addr_err
);
    import risc_mem_pkg::state_t;
    import risc_mem_pkg::CLEAR;
    import risc_mem_pkg::RUN;
    import risc_mem_pkg::addr_in_range;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_busy;

    logic          w_run;
    logic          w_in_range;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_wr_err;

    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_mem_rdata;

    logic          r_v1;
    logic          r_e1;
    logic          r_v2;
    logic          r_e2;
    logic [DW-1:0] r_d2;
    logic [DW-1:0] r_d_out;
    logic          r_rd_valid;
    logic          r_addr_err;

    // Requests are only looked at in RUN; during the sweep they vanish.
    assign w_run      = (r_state == RUN);
    assign w_in_range = addr_in_range(address, DEPTH);
    assign w_rd_acc   = w_run && rd_en;
    assign w_wr_acc   = w_run && mw_en && w_in_range;
    assign w_wr_err   = w_run && mw_en && !w_in_range;

    // The sweep owns the write port in CLEAR; the processor owns it in RUN.
    assign w_mem_we    = w_run ? w_wr_acc : 1'b1;
    assign w_mem_waddr = w_run ? address[AW-1:0] : r_clr_cnt;
    assign w_mem_wdata = w_run ? w_data : '0;

    mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_rd_acc),
        .i_raddr (address[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // CLEAR/RUN sequencer: sweep every word once, leave CLEAR on the edge
    // that zeroes the last word so busy drops on the following cycle.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            unique case (r_state)
                CLEAR: begin
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end
                RUN: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: data captured by the array on the accept edge, staged
    // once, then presented; out-of-range reads return zero. Write errors
    // flag on the edge they are requested and merge with read errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_e1       <= 1'b0;
            r_v2       <= 1'b0;
            r_e2       <= 1'b0;
            r_d2       <= '0;
            r_d_out    <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_v1 <= w_rd_acc;
            r_e1 <= w_rd_acc && !w_in_range;
            r_v2 <= r_v1;
            r_e2 <= r_e1;
            if (r_v1) begin
                r_d2 <= w_mem_rdata;
            end
            r_rd_valid <= r_v2;
            if (r_v2) begin
                r_d_out <= r_e2 ? '0 : r_d2;
            end
            r_addr_err <= (r_v2 && r_e2) || w_wr_err;
        end
    end

    assign D_in     = r_d_out;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: randomized and directed
// traffic against a queue-based reference model, checked by a monitor.
module tb_data_mem_responder;
    import risc_mem_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   address;
    logic [DW-1:0] w_data;
    logic          mw_en;
    logic          rd_en;
    logic [DW-1:0] D_in;
    logic          rd_valid;
    logic          busy;
    logic          addr_err;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .w_data   (w_data),
        .mw_en    (mw_en),
        .rd_en    (rd_en),
        .D_in     (D_in),
        .rd_valid (rd_valid),
        .busy     (busy),
        .addr_err (addr_err)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            err;
    } rd_exp_t;

    rd_exp_t       rq[$];       // expected read responses, in order
    int            wq[$];       // cycles on which a write error must show
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_run;
    int            model_clr;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last_dout;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    // Reference model: memory contents, sweep progress and the response
    // each accepted request must produce, keyed by the edge it appears on.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            rq.delete();
            wq.delete();
            model_run = 1'b0;
            model_clr = 0;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (!model_run) begin
            model_clr++;
            if (model_clr == DEPTH) model_run = 1'b1;
        end else begin
            if (mw_en) begin
                if (int'(address) < DEPTH) model_mem[int'(address)] = w_data;
                else wq.push_back(cyc);
            end
            if (rd_en) begin
                rd_exp_t e;
                e.due  = cyc + RD_LAT;
                e.err  = !(int'(address) < DEPTH);
                e.data = e.err ? '0 : model_mem[int'(address)];
                rq.push_back(e);
            end
        end
    end

    // Monitor: every cycle compare the DUT outputs with what the model says
    // is due now; D_in must hold its last returned value between pulses.
    rd_exp_t mon_e;
    bit      mon_v;
    bit      mon_err;
    always @(negedge clk) begin
        if (reset) begin
            check("rst_D_in", D_in, '0);
            check("rst_rd_valid", DW'(rd_valid), DW'(0));
            check("rst_addr_err", DW'(addr_err), DW'(0));
            check("rst_busy", DW'(busy), DW'(1));
            last_dout = '0;
        end else begin
            mon_v   = 1'b0;
            mon_err = 1'b0;
            check("busy", DW'(busy), DW'(!model_run));
            if (wq.size() > 0 && wq[0] == cyc) begin
                void'(wq.pop_front());
                mon_err = 1'b1;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mon_e     = rq.pop_front();
                mon_v     = 1'b1;
                mon_err   = mon_err | mon_e.err;
                last_dout = mon_e.data;
            end
            check("rd_valid", DW'(rd_valid), DW'(mon_v));
            check("D_in", D_in, last_dout);
            check("addr_err", DW'(addr_err), DW'(mon_err));
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [DW-1:0] data);
        rd_en   = rd;
        mw_en   = wr;
        address = addr;
        w_data  = data;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        mw_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        rd_en = 1'b0;
        mw_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Count busy cycles after reset release while throwing random requests
    // at the DUT; they must all be ignored.
    task automatic sweep(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            n++;
            rd_en   = 1'($urandom_range(0, 1));
            mw_en   = 1'($urandom_range(0, 1));
            address = 16'($urandom);
            w_data  = rand_data();
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        mw_en = 1'b0;
        check(name, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        logic [15:0] a;
        rd_en   = 1'b0;
        mw_en   = 1'b0;
        address = '0;
        w_data  = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        sweep("clear_len");

        // freshly cleared memory reads zero everywhere
        req(1, 0, 16'd0, '0);
        req(1, 0, 16'(DEPTH - 1), '0);
        for (int i = 0; i < 8; i++) req(1, 0, 16'($urandom_range(0, DEPTH - 1)), '0);
        idle(4);

        // write then read next cycle; simultaneous write+read same word
        req(0, 1, 16'd3, {(DW/8){8'hA5}});
        req(1, 0, 16'd3, '0);
        idle(4);
        req(1, 1, 16'd7, DW'(16'h1234));
        idle(4);

        // back-to-back reads, and a write right after a read's accept
        req(0, 1, 16'd0, rand_data());
        req(0, 1, 16'd1, rand_data());
        req(0, 1, 16'd2, rand_data());
        req(1, 0, 16'd0, '0);
        req(1, 0, 16'd1, '0);
        req(1, 0, 16'd2, '0);
        req(1, 0, 16'd1, '0);
        req(0, 1, 16'd1, rand_data());
        req(1, 0, 16'd1, '0);
        idle(4);

        // out-of-range accesses, top boundary, coincident error pulses
        req(1, 0, 16'h0100, '0);
        req(0, 1, 16'h0100, rand_data());
        req(1, 0, 16'd0, '0);
        req(0, 1, 16'(DEPTH - 1), rand_data());
        req(1, 0, 16'(DEPTH - 1), '0);
        req(1, 0, 16'hFFFF, '0);
        idle(1);
        req(0, 1, 16'h0200, rand_data());
        idle(4);

        // randomized mixed traffic, biased to collide on a few words
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 16'($urandom);
                1, 2:    a = 16'($urandom_range(0, DEPTH - 1));
                default: a = 16'($urandom_range(0, 7));
            endcase
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rand_data());
        end
        idle(4);

        // reset with two reads in flight: no responses, full sweep again
        req(0, 1, 16'd5, rand_data());
        req(1, 0, 16'd5, '0);
        req(1, 0, 16'd5, '0);
        apply_reset(2);
        sweep("clear_len_after_run_reset");
        req(1, 0, 16'd5, '0);
        req(1, 0, 16'd7, '0);
        idle(4);

        // reset in the middle of the sweep restarts it from word 0
        apply_reset(1);
        idle(100);
        apply_reset(1);
        sweep("clear_len_after_mid_clear_reset");
        req(1, 0, 16'd3, '0);
        idle(4);

        check("rd_queue_drained", DW'(rq.size()), DW'(0));
        check("wr_err_queue_drained", DW'(wq.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DW, default 128, data word width (matches the processor data bus).
REQ-002 Parameter DEPTH, default 256, number of storage words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  16  word address from the processor.
REQ-006 w_data  input  DW  write data (processor ALU result).
REQ-007 mw_en  input  1  write request, sampled each cycle.
REQ-008 rd_en  input  1  read request, sampled each cycle.
REQ-009 D_in  output  DW  read data returned to the processor.
REQ-010 rd_valid  output  1  one-cycle pulse marking D_in valid.
REQ-011 busy  output  1  high while requests are not accepted.
REQ-012 addr_err  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-013 The FSM SHALL have two states: CLEAR and RUN.
REQ-014 CLEAR SHALL write zero to words 0..DEPTH-1, one word per cycle, with busy=1.
REQ-015 The transition CLEAR->RUN SHALL occur on the edge that clears word DEPTH-1, so busy=0 from the next cycle.
REQ-016 While busy=1, mw_en and rd_en SHALL be ignored: no queuing, no addr_err, no rd_valid.
REQ-017 In RUN, mw_en=1 with address<DEPTH SHALL write w_data to that word on the same edge.
REQ-018 In RUN, rd_en=1 SHALL be accepted every cycle, giving one read per cycle with no stalls.
REQ-019 Read latency SHALL be exactly 2 cycles: a request accepted at edge N drives rd_valid=1 and D_in after edge N+2.
REQ-020 Read data SHALL reflect all writes up to and including the accept edge (write-first when mw_en and rd_en target the same address in one cycle).
REQ-021 Writes after the accept edge SHALL NOT alter an in-flight read's data.
REQ-022 A read with address>=DEPTH SHALL return D_in=0 and pulse addr_err aligned with its rd_valid.
REQ-023 A write with address>=DEPTH SHALL be dropped and pulse addr_err for one cycle after the request edge.
REQ-024 If a read error and a write error coincide on the same output cycle, addr_err SHALL be a single one-cycle pulse.
REQ-025 D_in SHALL hold its last value when rd_valid=0.
REQ-026 Only address bits [log2(DEPTH)-1:0] SHALL index storage; the range check uses the full 16 bits (no wrap-around aliasing).

Reset
REQ-027 reset asserted SHALL immediately force D_in=0, rd_valid=0, addr_err=0, busy=1, state=CLEAR, clear counter=0.
REQ-028 reset SHALL flush the read pipeline; in-flight reads produce no rd_valid.
REQ-029 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full CLEAR sweep after deassertion.

Structure
REQ-030 Package risc_mem_pkg SHALL hold DW, DEPTH, RD_LAT=2 and the CLEAR/RUN state enum.
REQ-031 Storage SHALL be a sub-module mem_array with one write port and one registered read port; the FSM, clear counter, range check and two-stage valid pipeline live in data_mem_responder.

Verification
REQ-032 Reset, then idle -> busy=1 for exactly 256 cycles, then 0; a read of any address returns 0.
REQ-033 Write 0xA5..A5 to addr 3, then read addr 3 the next cycle -> rd_valid two cycles after accept, D_in=0xA5..A5.
REQ-034 Same cycle: mw_en and rd_en both at addr 7 with data 0x1234 -> read returns 0x1234.
REQ-035 Reads to addrs 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses in order; a write to addr 1 one cycle after its accept does not change the returned data.
REQ-036 Read addr 0x0100 -> D_in=0 with addr_err=1, both aligned with rd_valid; write to 0x0100 -> addr_err pulses the next cycle and word 0 is unchanged.
REQ-037 Assert reset with two reads in flight -> no rd_valid, busy=1, and a full CLEAR reruns.
